stage_sum_ctrl: RTL and testbench
=================================

// Module: stage_sum_ctrl
// PURPOSE
//  Sequences leaf-value lookups for one cascade stage. Per stage it walks the stage's
//  feature range and takes one pass/fail decision per feature from feature evaluation.
//  Each decision drives a leaf-memory lookup (address + leaf_num); the signed leaf values
//  are accumulated and compared against the stage threshold.
//  Sits between feature evaluation and the leaf-value memory wrapper; feeds cascade control.
// PARAMETERS
//  W_LEAF        13    signed leaf value width
//  FEATURE_NUM   2913  total features; W_ADDR = $clog2(FEATURE_NUM) (localparam)
//  MAX_STAGE_FT  256   max features per stage; W_CNT = $clog2(MAX_STAGE_FT+1) (localparam)
//  W_ACC         21    signed accumulator/threshold width, >= W_LEAF + $clog2(MAX_STAGE_FT)
// PORTS
//  clk             in   1       clock; single clock domain
//  rst             in   1       synchronous, active-high reset
//  stage_valid     in   1       stage descriptor valid
//  stage_ready     out  1       descriptor accepted when valid&&ready
//  stage_first     in   W_ADDR  index of first feature of stage
//  stage_cnt       in   W_CNT   number of features in stage
//  stage_thr       in   W_ACC   signed stage threshold
//  dec_valid       in   1       feature decision valid (in feature order)
//  dec_ready       out  1       decision accepted when valid&&ready
//  dec_leaf        in   1       0 = pass leaf, 1 = fail leaf
//  leaf_addr_valid out  1       lookup request to leaf memory
//  leaf_addr_ready in   1       leaf memory accepts request
//  leaf_addr_data  out  W_ADDR  feature index of lookup
//  leaf_num        out  1       leaf select; drives the memory's data mux
//  leaf_data_valid in   1       leaf value returned
//  leaf_data_ready out  1       leaf value consumed
//  leaf_data       in   W_LEAF  signed leaf value
//  res_valid       out  1       stage result valid
//  res_ready       in   1       result consumed
//  res_pass        out  1       1 when sum >= threshold (signed)
//  res_sum         out  W_ACC   final signed stage sum
// BEHAVIOUR
//  - FSM: IDLE -> DEC -> REQ -> RESP -> (DEC | DONE) -> IDLE.
//  - IDLE: stage_ready=1; on accept, latch first/cnt/thr, idx<=0, acc<=0.
//    Go to DONE if cnt==0, else DEC.
//  - DEC: dec_ready=1; on accept, latch dec_leaf into leaf_num reg; go to REQ.
//  - REQ: leaf_addr_valid=1, addr = first+idx (W_ADDR wrap, no check). Hold addr/num
//    stable until handshake; on leaf_addr_ready go to RESP.
//  - RESP: leaf_data_ready=1; on leaf_data_valid: acc <= acc + sext(leaf_data), idx++.
//    If idx==cnt-1 go to DONE, else DEC.
//  - leaf_num is held unchanged from DEC accept through the RESP handshake.
//    Exactly one lookup is outstanding at any time.
//  - DONE: res_valid=1, res_sum=acc, res_pass=($signed(acc) >= $signed(thr)).
//    Hold until res_ready, then go to IDLE. stage_ready stays 0 until back in IDLE.
//  - cnt==0: DONE one cycle after accept; sum=0, pass=(0>=thr).
//  - Min per-feature latency 3 cycles (DEC, REQ, RESP with zero-wait partners).
//  - Handshake signals not listed for a state are 0 in that state.
//  - rst (any state, mid-stage included): state=IDLE, acc=0, idx=0, leaf_num=0.
//    All valid/ready outputs 0 except stage_ready, which is 1 the cycle after reset.
//    An in-flight memory response after reset is dropped (leaf_data_ready=0).
//  - Without saturation, acc wraps two's complement at W_ACC.
//  - Precondition: stage_first + stage_cnt <= FEATURE_NUM; stage_cnt <= MAX_STAGE_FT.
//    Assertions flag violations in simulation only.
// CONFIGURATION
//  STAGE_SUM_SAT_EN defined: accumulation saturates to the signed W_ACC min/max
//    instead of wrapping. Sticky res_sat (out, 1) is set on any clamp in the stage.
//    res_sat clears on stage accept and on reset.
//  STAGE_SUM_SAT_EN undefined: wrapping add; res_sat port absent.
// STRUCTURE
//  - cascade_pkg: W_LEAF and FEATURE_NUM defaults, the stage_sum_state_t enum
//    (IDLE, DEC, REQ, RESP, DONE), and a stage descriptor struct (first, cnt, thr).
//  - Sub-module stage_acc: signed add with sign-extension and optional saturation.
//    Ports: clk, rst, clr, en, din, acc, sat.
//  - FSM and counters live in stage_sum_ctrl.
// TESTING
//  - Stage first=10, cnt=3, thr=5; decisions 0,1,0; leaf values +4,-2,+6.
//    Expect addresses 10,11,12, leaf_num 0,1,0, res_sum=8, res_pass=1.
//  - cnt=0, thr=1 -> res_valid 1 cycle after accept, res_sum=0, res_pass=0.
//    Repeat with thr=-1 -> res_pass=1.
//  - leaf_addr_ready low for 4 cycles -> addr/leaf_num stable and no extra request.
//    leaf_data delayed 3 cycles -> single add; sum unchanged during the wait.
//  - res_ready held low 5 cycles -> res_* stable, stage_ready=0.
//    Next stage accepted the cycle after res_ready.
//  - rst asserted in RESP of feature 2 of 5 -> next cycle IDLE, stage_ready=1.
//    A new stage with cnt=1 and value -7 yields res_sum=-7.
//  - STAGE_SUM_SAT_EN, W_ACC=14: 3 x +4095 -> res_sum=8191, res_sat=1.
//    Without the macro -> res_sum wraps to -4099.

Source files
------------

// File: rtl/cascade_pkg.sv
// Shared types for the cascade stage datapath: parameter defaults, the stage-sum FSM
// state encoding and the stage descriptor held while a stage is being summed.
package cascade_pkg;

    localparam int W_LEAF_DEF       = 13;
    localparam int FEATURE_NUM_DEF  = 2913;
    localparam int MAX_STAGE_FT_DEF = 256;
    localparam int W_ACC_DEF        = 21;

    // Descriptor fields are sized generously so any legal parameterisation fits.
    localparam int W_DESC_ADDR = 16;
    localparam int W_DESC_CNT  = 16;
    localparam int W_DESC_THR  = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC  = 3'd1,
        REQ  = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } stage_sum_state_t;

    typedef struct packed {
        logic        [W_DESC_ADDR-1:0] first;
        logic        [W_DESC_CNT-1:0]  cnt;
        logic signed [W_DESC_THR-1:0]  thr;
    } stage_desc_t;

endpackage

// File: rtl/stage_acc.sv
// Signed leaf-value accumulator: sign-extends each leaf and adds it, wrapping by default
// or clamping to the signed range with a sticky flag when STAGE_SUM_SAT_EN is defined.
module stage_acc #(
    parameter int W_LEAF = 13,
    parameter int W_ACC  = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [W_LEAF-1:0] din,
    output logic [W_ACC-1:0]  acc
`ifdef STAGE_SUM_SAT_EN
    ,
    output logic              sat
`endif
);

    logic [W_ACC-1:0] din_ext;
    assign din_ext = W_ACC'($signed(din));

`ifdef STAGE_SUM_SAT_EN
    logic [W_ACC:0] sum_wide;
    logic           ovf;

    // One guard bit: overflow shows up as the guard and sign bits disagreeing.
    assign sum_wide = {acc[W_ACC-1], acc} + {din_ext[W_ACC-1], din_ext};
    assign ovf      = sum_wide[W_ACC] ^ sum_wide[W_ACC-1];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (en) begin
            if (ovf) begin
                acc <= sum_wide[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}};
                sat <= 1'b1;
            end else begin
                acc <= sum_wide[W_ACC-1:0];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din_ext;
        end
    end
`endif

endmodule

// File: rtl/stage_sum_ctrl.sv
// Per-stage leaf lookup sequencer: one decision -> one leaf lookup -> one add per feature,
// then a thresholded result. Optional saturation and res_sat port under STAGE_SUM_SAT_EN.
module stage_sum_ctrl
    import cascade_pkg::*;
#(
    parameter int  W_LEAF       = W_LEAF_DEF,
    parameter int  FEATURE_NUM  = FEATURE_NUM_DEF,
    parameter int  MAX_STAGE_FT = MAX_STAGE_FT_DEF,
    parameter int  W_ACC        = W_ACC_DEF,
    localparam int W_ADDR       = $clog2(FEATURE_NUM),
    localparam int W_CNT        = $clog2(MAX_STAGE_FT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stage_valid,
    output logic              stage_ready,
    input  logic [W_ADDR-1:0] stage_first,
    input  logic [W_CNT-1:0]  stage_cnt,
    input  logic [W_ACC-1:0]  stage_thr,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic              dec_leaf,
    output logic              leaf_addr_valid,
    input  logic              leaf_addr_ready,
    output logic [W_ADDR-1:0] leaf_addr_data,
    output logic              leaf_num,
    input  logic              leaf_data_valid,
    output logic              leaf_data_ready,
    input  logic [W_LEAF-1:0] leaf_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_pass,
    output logic [W_ACC-1:0]  res_sum,
`ifdef STAGE_SUM_SAT_EN
    output logic              res_sat,
`endif
    output logic [2:0]        state_dbg
);

    // Every valid/ready pair transfers on a rising edge where both are high; valids are
    // never withdrawn and their payload holds until that edge.

    stage_sum_state_t state, state_d;
    stage_desc_t      desc_q;
    logic [W_CNT-1:0] idx;
    logic             leaf_num_q;
    logic [W_ACC-1:0] acc_q;
    logic             stage_acc_fire;
    logic             dec_fire;
    logic             data_fire;
    logic             last_feature;

    assign stage_acc_fire = stage_valid && stage_ready;
    assign dec_fire       = dec_valid && dec_ready;
    assign data_fire      = leaf_data_valid && leaf_data_ready;
    assign last_feature   = (W_DESC_CNT'(idx) + W_DESC_CNT'(1)) == desc_q.cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            desc_q     <= '0;
            idx        <= '0;
            leaf_num_q <= 1'b0;
        end else begin
            state <= state_d;
            if (stage_acc_fire) begin
                desc_q.first <= W_DESC_ADDR'(stage_first);
                desc_q.cnt   <= W_DESC_CNT'(stage_cnt);
                desc_q.thr   <= W_DESC_THR'($signed(stage_thr));
                idx          <= '0;
            end
            if (dec_fire) begin
                leaf_num_q <= dec_leaf;
            end
            if (data_fire) begin
                idx <= idx + W_CNT'(1);
            end
        end
    end

    always_comb begin
        state_d         = state;
        stage_ready     = 1'b0;
        dec_ready       = 1'b0;
        leaf_addr_valid = 1'b0;
        leaf_data_ready = 1'b0;
        res_valid       = 1'b0;
        case (state)
            IDLE: begin
                stage_ready = 1'b1;
                if (stage_valid) begin
                    state_d = (stage_cnt == '0) ? DONE : DEC;
                end
            end
            DEC: begin
                dec_ready = 1'b1;
                if (dec_valid) state_d = REQ;
            end
            REQ: begin
                leaf_addr_valid = 1'b1;
                if (leaf_addr_ready) state_d = RESP;
            end
            RESP: begin
                leaf_data_ready = 1'b1;
                if (leaf_data_valid) state_d = last_feature ? DONE : DEC;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address wraps at W_ADDR; legal descriptors never reach the wrap.
    assign leaf_addr_data = W_ADDR'(desc_q.first + W_DESC_ADDR'(idx));
    assign leaf_num       = leaf_num_q;
    assign res_sum        = acc_q;
    assign res_pass       = $signed(W_DESC_THR'($signed(acc_q))) >= $signed(desc_q.thr);
    assign state_dbg      = state;

    stage_acc #(
        .W_LEAF(W_LEAF),
        .W_ACC (W_ACC)
    ) u_acc (
        .clk(clk),
        .rst(rst),
        .clr(stage_acc_fire),
        .en (data_fire),
        .din(leaf_data),
`ifdef STAGE_SUM_SAT_EN
        .acc(acc_q),
        .sat(res_sat)
`else
        .acc(acc_q)
`endif
    );

    stage_desc_ok: assert property (@(posedge clk) disable iff (rst)
        stage_acc_fire |-> ((int'(stage_first) + int'(stage_cnt) <= FEATURE_NUM)
                            && (int'(stage_cnt) <= MAX_STAGE_FT)));

endmodule

// File: tb/tb_stage_sum_ctrl.sv
// Bench for stage_sum_ctrl (W_ACC=14); build with or without STAGE_SUM_SAT_EN.
module tb_stage_sum_ctrl;
    import cascade_pkg::*;

    localparam int W_LEAF       = 13;
    localparam int FEATURE_NUM  = 2913;
    localparam int MAX_STAGE_FT = 256;
    localparam int W_ACC        = 14;
    localparam int W_ADDR       = $clog2(FEATURE_NUM);
    localparam int W_CNT        = $clog2(MAX_STAGE_FT + 1);
    localparam int W_RES        = W_ACC + 1;
    localparam int TMO          = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stage_valid = 1'b0;
    logic              stage_ready;
    logic [W_ADDR-1:0] stage_first = '0;
    logic [W_CNT-1:0]  stage_cnt = '0;
    logic [W_ACC-1:0]  stage_thr = '0;
    logic              dec_valid = 1'b0;
    logic              dec_ready;
    logic              dec_leaf = 1'b0;
    logic              leaf_addr_valid;
    logic              leaf_addr_ready = 1'b0;
    logic [W_ADDR-1:0] leaf_addr_data;
    logic              leaf_num;
    logic              leaf_data_valid = 1'b0;
    logic              leaf_data_ready;
    logic [W_LEAF-1:0] leaf_data = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_pass;
    logic [W_ACC-1:0]  res_sum;
`ifdef STAGE_SUM_SAT_EN
    logic              res_sat;
`endif
    logic [2:0]        state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W_RES-1:0]  exp_q[$];
    logic [W_ADDR:0]   lk_q[$];

    stage_sum_ctrl #(
        .W_LEAF(W_LEAF), .FEATURE_NUM(FEATURE_NUM), .MAX_STAGE_FT(MAX_STAGE_FT), .W_ACC(W_ACC)
    ) dut (
        .clk(clk), .rst(rst),
        .stage_valid(stage_valid), .stage_ready(stage_ready),
        .stage_first(stage_first), .stage_cnt(stage_cnt), .stage_thr(stage_thr),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_leaf(dec_leaf),
        .leaf_addr_valid(leaf_addr_valid), .leaf_addr_ready(leaf_addr_ready),
        .leaf_addr_data(leaf_addr_data), .leaf_num(leaf_num),
        .leaf_data_valid(leaf_data_valid), .leaf_data_ready(leaf_data_ready),
        .leaf_data(leaf_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass),
        .res_sum(res_sum),
`ifdef STAGE_SUM_SAT_EN
        .res_sat(res_sat),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [W_RES-1:0] model_stage(input int vals[$], input int thr);
        logic signed [W_ACC-1:0] acc = '0;
        int s;
        foreach (vals[i]) begin
`ifdef STAGE_SUM_SAT_EN
            s = int'(acc) + vals[i];
            if (s > (2 ** (W_ACC - 1)) - 1)  acc = {1'b0, {(W_ACC-1){1'b1}}};
            else if (s < -(2 ** (W_ACC - 1))) acc = {1'b1, {(W_ACC-1){1'b0}}};
            else                              acc = W_ACC'(s);
`else
            s = vals[i];
            acc = acc + W_ACC'(s);
`endif
        end
        return {(int'(acc) >= thr), acc};
    endfunction

    // ---------------- driver tasks (all start and end on a negedge) ----------------
    task automatic send_stage(input int first, input int cnt, input int thr,
                              output int waited, output bit ok);
        stage_valid = 1'b1;
        stage_first = W_ADDR'(first);
        stage_cnt   = W_CNT'(cnt);
        stage_thr   = W_ACC'(thr);
        waited = 0;
        while (!stage_ready && waited < TMO) begin
            @(negedge clk);
            waited++;
        end
        ok = stage_ready;
        @(negedge clk);
        stage_valid = 1'b0;
    endtask

    task automatic do_feature(input bit dec, input int val, input int addr_wait,
                              input int data_wait, output logic [W_ADDR:0] seen,
                              output bit stable, output bit ok);
        int t;
        logic [W_ACC-1:0] s0;
        ok = 1'b1;
        stable = 1'b1;
        dec_valid = 1'b1;
        dec_leaf  = dec;
        t = 0;
        while (!dec_ready && t < TMO) begin @(negedge clk); t++; end
        if (!dec_ready) ok = 1'b0;
        @(negedge clk);
        dec_valid = 1'b0;
        dec_leaf  = 1'b0;
        t = 0;
        while (!leaf_addr_valid && t < TMO) begin @(negedge clk); t++; end
        if (!leaf_addr_valid) ok = 1'b0;
        seen = {leaf_addr_data, leaf_num};
        repeat (addr_wait) begin
            @(negedge clk);
            if (!leaf_addr_valid || {leaf_addr_data, leaf_num} !== seen) stable = 1'b0;
        end
        leaf_addr_ready = 1'b1;
        @(negedge clk);
        leaf_addr_ready = 1'b0;
        if (leaf_addr_valid) stable = 1'b0;
        t = 0;
        while (!leaf_data_ready && t < TMO) begin @(negedge clk); t++; end
        if (!leaf_data_ready) ok = 1'b0;
        s0 = res_sum;
        repeat (data_wait) begin
            @(negedge clk);
            if (!leaf_data_ready || leaf_num !== seen[0] || res_sum !== s0) stable = 1'b0;
        end
        leaf_data_valid = 1'b1;
        leaf_data = W_LEAF'(val);
        @(negedge clk);
        leaf_data_valid = 1'b0;
        leaf_data = '0;
    endtask

    task automatic take_result(input int hold, output logic [W_RES-1:0] got,
                               output bit stable, output bit ok);
        int t = 0;
        stable = 1'b1;
        while (!res_valid && t < TMO) begin @(negedge clk); t++; end
        ok  = res_valid;
        got = {res_pass, res_sum};
        repeat (hold) begin
            @(negedge clk);
            if (!res_valid || {res_pass, res_sum} !== got || stage_ready) stable = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stage_ready !== 1'b1) $display("FAIL reset_stage_ready: got %b want 1", stage_ready);
        else n_pass++;
        n_checks++;
        if ({dec_ready, leaf_addr_valid, leaf_data_ready, res_valid} !== 4'b0000)
            $display("FAIL reset_handshakes: got %b want 0000",
                     {dec_ready, leaf_addr_valid, leaf_data_ready, res_valid});
        else n_pass++;
        n_checks++;
        if (state_dbg !== 3'(IDLE)) $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
        else n_pass++;
        n_checks++;
        if ({leaf_num, res_sum} !== '0) $display("FAIL reset_num_sum: got %b/%0d want 0/0", leaf_num, res_sum);
        else n_pass++;
    endtask

    task automatic test_basic();
        int vals[$] = '{4, -2, 6};
        bit decs[3] = '{1'b0, 1'b1, 1'b0};
        logic [W_ADDR:0]  seen, exp_lk;
        logic [W_RES-1:0] got, exp_r;
        int waited;
        bit ok, stable;
        exp_q.push_back(model_stage(vals, 5));
        send_stage(10, 3, 5, waited, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_accept: stage not accepted within %0d cycles", TMO);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            lk_q.push_back({W_ADDR'(10 + i), decs[i]});
            do_feature(decs[i], vals[i], 0, 0, seen, stable, ok);
            exp_lk = lk_q.pop_front();
            n_checks++;
            if (!ok || seen !== exp_lk)
                $display("FAIL basic_lookup%0d: got addr %0d num %b ok %b want addr %0d num %b",
                         i, seen[W_ADDR:1], seen[0], ok, exp_lk[W_ADDR:1], exp_lk[0]);
            else n_pass++;
        end
        take_result(0, got, stable, ok);
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp_r)
            $display("FAIL basic_result: got sum %0d pass %b want sum %0d pass %b",
                     $signed(got[W_ACC-1:0]), got[W_ACC], $signed(exp_r[W_ACC-1:0]), exp_r[W_ACC]);
        else n_pass++;
`ifdef STAGE_SUM_SAT_EN
        n_checks++;
        if (res_sat !== 1'b0) $display("FAIL basic_sat: got %b want 0", res_sat);
        else n_pass++;
`endif
    endtask

    task automatic test_empty_stage();
        int none[$];
        int thrs[2] = '{1, -1};
        logic [W_RES-1:0] got, exp_r;
        int waited;
        bit ok, stable;
        none.delete();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model_stage(none, thrs[i]));
            send_stage(500, 0, thrs[i], waited, ok);
            n_checks++;
            if (!ok || res_valid !== 1'b1)
                $display("FAIL empty%0d_latency: res_valid %b one cycle after accept, want 1", i, res_valid);
            else n_pass++;
            take_result(0, got, stable, ok);
            exp_r = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp_r)
                $display("FAIL empty%0d_result: got sum %0d pass %b want sum %0d pass %b", i,
                         $signed(got[W_ACC-1:0]), got[W_ACC], $signed(exp_r[W_ACC-1:0]), exp_r[W_ACC]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int vals[$] = '{5, 7};
        logic [W_ADDR:0]  seen, exp_lk;
        logic [W_RES-1:0] got, exp_r;
        int waited;
        bit ok, stable;
        exp_q.push_back(model_stage(vals, 0));
        send_stage(100, 2, 0, waited, ok);
        lk_q.push_back({W_ADDR'(100), 1'b1});
        do_feature(1'b1, vals[0], 4, 3, seen, stable, ok);
        exp_lk = lk_q.pop_front();
        n_checks++;
        if (!ok || seen !== exp_lk)
            $display("FAIL stall_lookup: got addr %0d num %b want addr %0d num %b",
                     seen[W_ADDR:1], seen[0], exp_lk[W_ADDR:1], exp_lk[0]);
        else n_pass++;
        n_checks++;
        if (!stable) $display("FAIL stall_stable: got stable 0 want 1 during addr/data waits");
        else n_pass++;
        lk_q.push_back({W_ADDR'(101), 1'b0});
        do_feature(1'b0, vals[1], $urandom_range(0, 3), $urandom_range(0, 3), seen, stable, ok);
        exp_lk = lk_q.pop_front();
        n_checks++;
        if (!ok || !stable || seen !== exp_lk)
            $display("FAIL stall_lookup2: got addr %0d num %b stable %b want addr %0d num %b stable 1",
                     seen[W_ADDR:1], seen[0], stable, exp_lk[W_ADDR:1], exp_lk[0]);
        else n_pass++;
        take_result(0, got, stable, ok);
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp_r)
            $display("FAIL stall_result: got sum %0d want %0d", $signed(got[W_ACC-1:0]),
                     $signed(exp_r[W_ACC-1:0]));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int va[$] = '{3};
        int vb[$] = '{-1};
        logic [W_ADDR:0]  seen;
        logic [W_RES-1:0] got, exp_r;
        int waited;
        bit ok, stable;
        exp_q.push_back(model_stage(va, 10));
        send_stage(200, 1, 10, waited, ok);
        do_feature(1'b1, va[0], 0, 0, seen, stable, ok);
        take_result(5, got, stable, ok);
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!ok || !stable || got !== exp_r)
            $display("FAIL hold_result: got sum %0d pass %b stable %b want sum %0d pass %b stable 1",
                     $signed(got[W_ACC-1:0]), got[W_ACC], stable, $signed(exp_r[W_ACC-1:0]), exp_r[W_ACC]);
        else n_pass++;
        exp_q.push_back(model_stage(vb, -1));
        send_stage(300, 1, -1, waited, ok);
        n_checks++;
        if (!ok || waited != 0) $display("FAIL b2b_accept: got wait %0d cycles want 0", waited);
        else n_pass++;
        do_feature(1'b0, vb[0], 0, 0, seen, stable, ok);
        take_result(0, got, stable, ok);
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp_r)
            $display("FAIL b2b_result: got sum %0d pass %b want sum %0d pass %b",
                     $signed(got[W_ACC-1:0]), got[W_ACC], $signed(exp_r[W_ACC-1:0]), exp_r[W_ACC]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int vn[$] = '{-7};
        logic [W_ADDR:0]  seen;
        logic [W_RES-1:0] got, exp_r;
        int waited, t;
        bit ok, stable;
        send_stage(50, 5, 0, waited, ok);
        do_feature(1'b1, 9, 0, 0, seen, stable, ok);
        dec_valid = 1'b1;
        dec_leaf  = 1'b1;
        t = 0;
        while (!dec_ready && t < TMO) begin @(negedge clk); t++; end
        @(negedge clk);
        dec_valid = 1'b0;
        dec_leaf  = 1'b0;
        leaf_addr_ready = 1'b1;
        @(negedge clk);
        leaf_addr_ready = 1'b0;
        n_checks++;
        if (leaf_data_ready !== 1'b1) $display("FAIL rstmid_in_resp: got leaf_data_ready %b want 1", leaf_data_ready);
        else n_pass++;
        rst = 1'b1;
        leaf_data_valid = 1'b1;
        leaf_data = W_LEAF'(100);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (stage_ready !== 1'b1 || leaf_data_ready !== 1'b0 || state_dbg !== 3'(IDLE))
            $display("FAIL rstmid_idle: got stage_ready %b leaf_data_ready %b state %0d want 1 0 %0d",
                     stage_ready, leaf_data_ready, state_dbg, IDLE);
        else n_pass++;
        n_checks++;
        if ({leaf_num, res_sum} !== '0) $display("FAIL rstmid_clear: got num %b sum %0d want 0 0", leaf_num, res_sum);
        else n_pass++;
        @(negedge clk);
        leaf_data_valid = 1'b0;
        leaf_data = '0;
        exp_q.push_back(model_stage(vn, 0));
        send_stage(60, 1, 0, waited, ok);
        do_feature(1'b0, vn[0], 0, 0, seen, stable, ok);
        take_result(0, got, stable, ok);
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp_r)
            $display("FAIL rstmid_result: got sum %0d pass %b want sum %0d pass %b",
                     $signed(got[W_ACC-1:0]), got[W_ACC], $signed(exp_r[W_ACC-1:0]), exp_r[W_ACC]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int vals[$] = '{4095, 4095, 4095};
        logic [W_ADDR:0]  seen;
        logic [W_RES-1:0] got, exp_r;
        int waited;
        bit ok, stable;
        exp_q.push_back(model_stage(vals, 0));
        send_stage(400, 3, 0, waited, ok);
        for (int i = 0; i < 3; i++) do_feature(1'b0, vals[i], 0, 0, seen, stable, ok);
        take_result(0, got, stable, ok);
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp_r)
            $display("FAIL wrap_result: got sum %0d pass %b want sum %0d pass %b",
                     $signed(got[W_ACC-1:0]), got[W_ACC], $signed(exp_r[W_ACC-1:0]), exp_r[W_ACC]);
        else n_pass++;
`ifdef STAGE_SUM_SAT_EN
        n_checks++;
        if (res_sat !== 1'b1) $display("FAIL wrap_sat: got %b want 1", res_sat);
        else n_pass++;
`endif
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_empty_stage();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
